// File: rtl/uart_mem_dumper_pkg.sv
// uart_mem_dumper_pkg: FSM states, 8N1 frame constants and baud divisor helper shared by the dumper
package uart_mem_dumper_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_LATCH, S_SEND, S_CSUM, S_FIN} state_t;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam int DATA_BITS = 8;
    localparam int BYTES_PER_WORD = 4;
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/uart_mem_dumper_tx_byte.sv
// uart_mem_dumper_tx_byte: 8N1 byte serializer; ready rises in the last stop-bit clock so bytes chain back-to-back
module uart_mem_dumper_tx_byte
    import uart_mem_dumper_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4687
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    logic          active;
    logic [7:0]    shift;
    logic [3:0]    bit_idx;
    logic [CW-1:0] baud;
    logic          bit_end;
    assign bit_end = baud == CW'(CLKS_PER_BIT - 1);
    assign ready_o = !active || (bit_idx == 4'(DATA_BITS + 1) && bit_end);
    // bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active  <= 1'b0;
            shift   <= '0;
            bit_idx <= '0;
            baud    <= '0;
            tx_o    <= STOP_BIT;
        end else if (valid_i && ready_o) begin
            active  <= 1'b1;
            shift   <= data_i;
            bit_idx <= '0;
            baud    <= '0;
            tx_o    <= START_BIT;
        end else if (active) begin
            if (bit_end) begin
                baud <= '0;
                if (bit_idx == 4'(DATA_BITS + 1)) begin
                    active <= 1'b0;
                    tx_o   <= STOP_BIT;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx_o    <= bit_idx == 4'(DATA_BITS) ? STOP_BIT : shift[bit_idx[2:0]];
                end
            end else begin
                baud <= baud + 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_mem_dumper.sv
// uart_mem_dumper: reads a block of SRAM words and sends each as 4 little-endian 8N1 bytes.
// Define UART_DUMP_CHECKSUM_EN to append a modulo-256 sum of all data bytes after the last word.
module uart_mem_dumper
    import uart_mem_dumper_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 45000000,
    parameter int BAUD         = 9600,
    parameter int ADDR_WIDTH   = 13
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [15:0]           word_count_i,
    output logic                  mem_csb_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [31:0]           mem_data_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);
`ifdef UART_DUMP_CHECKSUM_EN
    localparam state_t EMPTY_NEXT = S_CSUM;
    logic [7:0] sum;
`else
    localparam state_t EMPTY_NEXT = S_FIN;
`endif
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           remaining;
    logic [31:0]           word;
    logic [2:0]            byte_idx;
    logic                  tx_valid, tx_ready;
    logic [7:0]            tx_data;
    logic                  last_word;

    assign last_word  = remaining == 16'd1;
    assign mem_csb_o  = state != S_RD;
    assign mem_addr_o = addr;
    assign busy_o     = state != S_IDLE && state != S_FIN;
    assign done_o     = state == S_FIN;

    // state register
    always_ff @(posedge clk_i) state <= reset_i ? S_IDLE : state_nxt;

    // next state and byte feed; byte 0 goes straight from the SRAM bus so the start bit follows LATCH
    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = word[{byte_idx[1:0], 3'b000} +: 8];
        case (state)
            S_IDLE:  if (start_i) state_nxt = word_count_i != 16'd0 ? S_RD : EMPTY_NEXT;
            S_RD:    state_nxt = S_LATCH;
            S_LATCH: begin
                tx_valid  = 1'b1;
                tx_data   = mem_data_i[7:0];
                state_nxt = S_SEND;
            end
            S_SEND: if (tx_ready) begin
                if (byte_idx != 3'(BYTES_PER_WORD)) tx_valid = 1'b1;
                else if (!last_word) state_nxt = S_RD;
                else begin
`ifdef UART_DUMP_CHECKSUM_EN
                    tx_valid  = 1'b1;
                    tx_data   = sum;
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_FIN;
`endif
                end
            end
`ifdef UART_DUMP_CHECKSUM_EN
            S_CSUM: if (tx_ready) begin
                if (byte_idx == 3'd0) begin
                    tx_valid = 1'b1;
                    tx_data  = sum;
                end else state_nxt = S_FIN;
            end
`endif
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // word/address bookkeeping; the address only moves when entering RD so it holds while csb is high
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr      <= '0;
            remaining <= '0;
            word      <= '0;
            byte_idx  <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            if (state == S_IDLE && start_i) begin
                remaining <= word_count_i;
                byte_idx  <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
                sum       <= '0;
`endif
                if (word_count_i != 16'd0) addr <= base_addr_i;
            end
            if (state == S_LATCH) word <= mem_data_i;
            if (tx_valid) byte_idx <= byte_idx + 3'd1;
`ifdef UART_DUMP_CHECKSUM_EN
            if (tx_valid && state_nxt != S_CSUM) sum <= sum + tx_data;
`endif
            if (state == S_SEND && state_nxt == S_RD) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 16'd1;
                byte_idx  <= '0;
            end
        end
    end

    uart_mem_dumper_tx_byte #(
        .CLKS_PER_BIT(clks_per_bit(SYS_CLK_FREQ, BAUD))
    ) u_tx (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .data_i (tx_data),
        .valid_i(tx_valid),
        .ready_o(tx_ready),
        .tx_o   (tx_o)
    );
endmodule

// File: tb/tb_uart_mem_dumper.sv
// tb_uart_mem_dumper: random SRAM images dumped over UART, decoded by a line monitor and compared to a byte-level model
module tb_uart_mem_dumper;
    localparam int CPB = 10;
    localparam int AW  = 13;
`ifdef UART_DUMP_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [15:0]   word_count_i = '0;
    logic          mem_csb_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data = '0;
    logic          tx_o, busy_o, done_o;
    logic [31:0]   mem [0:(1<<AW)-1];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [7:0]    rx_q[$];
    logic          stop_q[$];
    logic [AW-1:0] rd_q[$];
    int            done_cnt = 0;
    int            epoch = 0;

    uart_mem_dumper #(.SYS_CLK_FREQ(100), .BAUD(10), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .word_count_i(word_count_i), .mem_csb_o(mem_csb_o), .mem_addr_o(mem_addr_o),
        .mem_data_i(mem_data), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!mem_csb_o) mem_data <= mem[mem_addr_o];

    always @(negedge clk) begin
        if (!mem_csb_o) rd_q.push_back(mem_addr_o);
        if (done_o) done_cnt++;
    end

    initial begin : rx_mon
        logic [7:0] b;
        int ep;
        forever begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                ep = epoch;
                repeat (CPB/2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx_o;
                end
                repeat (CPB) @(negedge clk);
                if (ep == epoch) begin
                    rx_q.push_back(b);
                    stop_q.push_back(tx_o);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_dump(input logic [AW-1:0] base, input int count, input int restart_at, input string name);
        logic [7:0]  exp_q[$];
        logic [7:0]  sum;
        logic [31:0] w;
        int dur, n, busy_n, tx_low, exp_low, d0, bad_stop;
        sum = 8'd0;
        exp_low = 0;
        for (int i = 0; i < count; i++) begin
            w = mem[AW'(base + AW'(i))];
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back(w[8*j +: 8]);
                sum += w[8*j +: 8];
            end
        end
        if (CK) exp_q.push_back(sum);
        foreach (exp_q[i]) exp_low += (9 - $countones(exp_q[i])) * CPB;
        dur = count * (2 + 40*CPB) + (CK ? 10*CPB : 0) + 1;
        rx_q.delete();
        stop_q.delete();
        rd_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        start_i = 1'b1;
        base_addr_i = base;
        word_count_i = 16'(count);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        base_addr_i = AW'($urandom);
        word_count_i = 16'($urandom);
        n = 0;
        busy_n = 0;
        tx_low = 0;
        forever begin
            n++;
            if (tx_o == 1'b0) tx_low++;
            if (done_o) break;
            if (busy_o) busy_n++;
            if (n == restart_at) begin
                start_i = 1'b1;
                base_addr_i = AW'(100);
                word_count_i = 16'd5;
            end
            if (n == restart_at + 1) start_i = 1'b0;
            if (n > dur + 50) begin
                check({name, " timeout"}, 32'(n), 32'(dur));
                break;
            end
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        check({name, " done cycle"}, 32'(n), 32'(dur));
        check({name, " busy at done"}, 32'(busy_o), 32'd0);
        check({name, " busy cycles"}, 32'(busy_n), 32'((count == 0 && !CK) ? 0 : dur - 1));
        check({name, " tx low cycles"}, 32'(tx_low), 32'(exp_low));
        @(posedge clk);
        #1;
        check({name, " done pulse width"}, 32'(done_o), 32'd0);
        check({name, " done count"}, 32'(done_cnt - d0), 32'd1);
        check({name, " byte count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        bad_stop = 0;
        foreach (stop_q[i]) if (stop_q[i] !== 1'b1) bad_stop++;
        check({name, " stop bits"}, 32'(bad_stop), 32'd0);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
        check({name, " sram reads"}, 32'(rd_q.size()), 32'(count));
        for (int i = 0; i < count && i < rd_q.size(); i++)
            check($sformatf("%s addr%0d", name, i), 32'(rd_q[i]), 32'(AW'(base + AW'(i))));
    endtask

    task automatic reset_mid(input logic [AW-1:0] base);
        int at, n, d0;
        at = 3 + 21*CPB + $urandom_range(0, 8*CPB - 1);
        d0 = done_cnt;
        @(negedge clk);
        start_i = 1'b1;
        base_addr_i = base;
        word_count_i = 16'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        n = 1;
        while (n < at) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst busy before", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        epoch++;
        @(posedge clk);
        #1;
        check("rst tx", 32'(tx_o), 32'd1);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst csb", 32'(mem_csb_o), 32'd1);
        check("rst done", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        check("rst no done", 32'(done_cnt - d0), 32'd0);
        check("rst tx idle", 32'(tx_o), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", 32'(tx_o), 32'd1);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset csb", 32'(mem_csb_o), 32'd1);
        check("reset addr", 32'(mem_addr_o), 32'd0);
        reset_i = 1'b0;
        mem[4] = 32'h44332211;
        run_dump(AW'(4), 1, 0, "t1");
        run_dump(AW'((1 << AW) - 2), 3, 0, "t2 wrap");
        run_dump(AW'(7), 0, 0, "t3 empty");
        run_dump(AW'(20), 3, 150, "t4 restart");
        reset_mid(AW'(40));
        run_dump(AW'(60), 2, 0, "t5 after reset");
        mem[200] = 32'h000000FF;
        mem[201] = 32'h00000002;
        run_dump(AW'(200), 2, 0, "t6 sum");
        for (int r = 0; r < 4; r++)
            run_dump(AW'($urandom), int'($urandom_range(1, 3)), 0, $sformatf("rand%0d", r));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
